wb_slave_bridge_gen: RTL and testbench

//  Parametrised Wishbone B3 classic slave front-end for the peripheral register banks (SPI master, UART, ...).

---
 rtl/wb_slave_bridge_gen.sv | 171 +++++++++++++++++
 tb/tb_wb_slave_bridge_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_bridge_gen.sv
// Wishbone B3 classic slave front-end: registers the bus, issues a one-cycle strobe to the
// core register file, then returns ACK/ERR (on core completion or timeout) and a hold-off gap.
module wb_slave_bridge_gen #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned HOLDOFF = 2,
   localparam int unsigned SEL_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              wb_rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o,
   output logic              wb_inta_o,
   input  logic              core_inta_i,
   output logic [ADDR_W-1:0] core_adr_o,
   output logic [DATA_W-1:0] core_dat_o,
   output logic [SEL_W-1:0]  core_sel_o,
   output logic              core_we_o,
   output logic              core_re_o,
   input  logic [DATA_W-1:0] core_dat_i,
   input  logic              core_ack_i,
   input  logic              core_err_i
);

   localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StHold} state_e;

   // Classic cycles only: burst qualifiers are accepted and dropped.
   logic unused_cti_bte;
   assign unused_cti_bte = ^{wb_cti_i, wb_bte_i};

   logic              cyc_s, stb_s, we_s;
   logic [SEL_W-1:0]  sel_s;
   logic [ADDR_W-1:0] adr_s;
   logic [DATA_W-1:0] dat_s;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [3:0]        hold_cnt_q, hold_cnt_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdat_q, rdat_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic [SEL_W-1:0]  sel_q, sel_d;

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cyc_s <= 1'b0;
         stb_s <= 1'b0;
         we_s  <= 1'b0;
         sel_s <= '0;
         adr_s <= '0;
         dat_s <= '0;
      end else begin
         cyc_s <= wb_cyc_i;
         stb_s <= wb_stb_i;
         we_s  <= wb_we_i;
         sel_s <= wb_sel_i;
         adr_s <= wb_adr_i;
         dat_s <= wb_dat_i;
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         to_cnt_q   <= '0;
         hold_cnt_q <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         rdat_q     <= '0;
         adr_q      <= '0;
         wdat_q     <= '0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         we_q       <= we_d;
         err_q      <= err_d;
         rdat_q     <= rdat_d;
         adr_q      <= adr_d;
         wdat_q     <= wdat_d;
         sel_q      <= sel_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      hold_cnt_d = hold_cnt_q;
      we_d       = we_q;
      err_d      = err_q;
      rdat_d     = rdat_q;
      adr_d      = adr_q;
      wdat_d     = wdat_q;
      sel_d      = sel_q;

      unique case (state_q)
         StIdle: begin
            if (cyc_s && stb_s) begin
               adr_d    = adr_s;
               wdat_d   = dat_s;
               sel_d    = sel_s;
               we_d     = we_s;
               err_d    = 1'b0;
               to_cnt_d = '0;
               state_d  = StIssue;
            end
         end
         StIssue, StWait: begin
            if (!cyc_s) begin
               // Master abandoned the cycle: no termination, any late core ack is dropped.
               hold_cnt_d = '0;
               state_d    = StHold;
            end else if (core_ack_i) begin
               if (!we_q) rdat_d = core_dat_i;
               err_d   = core_err_i;
               state_d = StResp;
            end else if (state_q == StIssue) begin
               state_d = StWait;
            end else if (TIMEOUT != 0) begin
               // Leaves after TIMEOUT complete WAIT cycles without a core ack.
               to_cnt_d = to_cnt_q + 1'b1;
               if (to_cnt_d == TO_W'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            hold_cnt_d = '0;
            state_d    = StHold;
         end
         StHold: begin
            // Masks the registered stb that still shows the request just terminated.
            if (hold_cnt_q == 4'(HOLDOFF - 1)) begin
               state_d = StIdle;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wb_dat_o   = rdat_q;
   assign wb_ack_o   = (state_q == StResp) && !err_q;
   assign wb_err_o   = (state_q == StResp) && err_q;
   assign wb_rty_o   = 1'b0;
   assign wb_inta_o  = core_inta_i;
   assign core_adr_o = adr_q;
   assign core_dat_o = wdat_q;
   assign core_sel_o = sel_q;
   assign core_we_o  = (state_q == StIssue) && we_q;
   assign core_re_o  = (state_q == StIssue) && !we_q;

endmodule

// File: tb/tb_wb_slave_bridge_gen.sv
// Scoreboard bench for wb_slave_bridge_gen: a behavioural core answers strobes with a
// programmable latency, and every ACK/ERR is matched against an expected-response queue.
module tb_wb_slave_bridge_gen;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = '0;
   logic [7:0]  wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o, wb_inta_o;
   logic        core_inta_i = 1'b0;
   logic [7:0]  core_adr_o;
   logic [31:0] core_dat_o;
   logic [3:0]  core_sel_o;
   logic        core_we_o, core_re_o;
   logic [31:0] core_dat_i = '0;
   logic        core_ack_i = 1'b0, core_err_i = 1'b0;

   wb_slave_bridge_gen #(
      .ADDR_W(8), .DATA_W(32), .TIMEOUT(16), .HOLDOFF(2)
   ) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_inta_o(wb_inta_o),
      .core_inta_i(core_inta_i), .core_adr_o(core_adr_o), .core_dat_o(core_dat_o),
      .core_sel_o(core_sel_o), .core_we_o(core_we_o), .core_re_o(core_re_o),
      .core_dat_i(core_dat_i), .core_ack_i(core_ack_i), .core_err_i(core_err_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0, bad = 0;
   int          cyc_cnt = 0, resp_cnt = 0, strobe_cnt = 0;
   int          str_cyc = -1;
   logic [7:0]  str_adr;
   logic [31:0] str_dat;
   logic [3:0]  str_sel;
   logic        str_we;
   int          core_lat = 0;
   logic        core_err_cfg = 1'b0;
   logic [31:0] core_rdata = '0;

   initial forever begin
      @(posedge clk);
      cyc_cnt++;
   end

   // Strobe recorder: counts every cycle a core strobe is high.
   initial forever begin
      @(negedge clk);
      if (!wb_rst_i && (core_we_o || core_re_o)) begin
         strobe_cnt++;
         str_cyc = cyc_cnt;
         str_adr = core_adr_o;
         str_dat = core_dat_o;
         str_sel = core_sel_o;
         str_we  = core_we_o;
      end
   end

   // Behavioural core: latency 0 acks inside the strobe cycle, negative never acks.
   initial forever begin
      @(negedge clk);
      if (!wb_rst_i && (core_we_o || core_re_o) && core_lat >= 0) begin
         if (core_lat > 0) begin
            repeat (core_lat) @(posedge clk);
            #1;
         end
         core_ack_i = 1'b1;
         core_err_i = core_err_cfg;
         core_dat_i = core_rdata;
         @(posedge clk);
         #1;
         core_ack_i = 1'b0;
         core_err_i = 1'b0;
      end
   end

   // Response monitor / scoreboard pop.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!wb_rst_i && (wb_ack_o || wb_err_o)) begin
         resp_cnt++;
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp: ack=%b err=%b, required no response", wb_ack_o,
                     wb_err_o);
         end else begin
            e = sb_q.pop_front();
            if ({wb_ack_o, wb_err_o} !== {~e.err, e.err}) begin
               bad++;
               $display("FAIL resp_kind: ack=%b err=%b, required ack=%b err=%b", wb_ack_o,
                        wb_err_o, ~e.err, e.err);
            end
            if (e.chk) begin
               total++;
               if (wb_dat_o !== e.dat) begin
                  bad++;
                  $display("FAIL resp_data: wb_dat_o=%h, required %h", wb_dat_o, e.dat);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit extra, input exp_t e,
                          output int lat, output int rcyc);
      int t0;
      bit seen;
      @(posedge clk);
      #1;
      sb_q.push_back(e);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      t0 = cyc_cnt;
      seen = 1'b0; lat = -1; rcyc = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) begin
            seen = 1'b1;
            rcyc = cyc_cnt;
            lat  = cyc_cnt - t0;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL xfer_no_resp: adr=%h no response in 60 cycles, required ack or err", adr);
         sb_q.delete();
      end
      @(posedge clk);
      #1;
      if (extra) begin
         @(posedge clk);
         #1;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({wb_ack_o, wb_err_o, wb_rty_o, core_we_o, core_re_o} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: ack/err/rty/we/re=%b, required 00000",
                  {wb_ack_o, wb_err_o, wb_rty_o, core_we_o, core_re_o});
      end
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      @(negedge clk);
      total++;
      if (wb_dat_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_dat: wb_dat_o=%h, required 0", wb_dat_o);
      end
      total++;
      if ({core_adr_o, core_dat_o, core_sel_o} !== 44'h0) begin
         bad++;
         $display("FAIL reset_core_bus: adr=%h dat=%h sel=%h, required 0", core_adr_o,
                  core_dat_o, core_sel_o);
      end
      core_inta_i = 1'b1;
      #1;
      total++;
      if (wb_inta_o !== 1'b1) begin
         bad++;
         $display("FAIL inta: wb_inta_o=%b, required 1", wb_inta_o);
      end
      core_inta_i = 1'b0;
   endtask

   task automatic test_write;
      int lat, rcyc, s0;
      core_lat = 0; core_err_cfg = 1'b0;
      s0 = strobe_cnt;
      wb_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, {1'b0, 1'b0, 32'h0}, lat, rcyc);
      total++;
      if (lat !== 3) begin
         bad++;
         $display("FAIL write_latency: %0d cycles, required 3", lat);
      end
      total++;
      if (strobe_cnt - s0 !== 1 || str_we !== 1'b1 || str_cyc !== rcyc - 1) begin
         bad++;
         $display("FAIL write_strobe: count=%0d we=%b at=%0d, required 1 1 %0d",
                  strobe_cnt - s0, str_we, str_cyc, rcyc - 1);
      end
      total++;
      if ({str_adr, str_dat, str_sel} !== {8'h10, 32'hDEADBEEF, 4'hF}) begin
         bad++;
         $display("FAIL write_fields: adr=%h dat=%h sel=%h, required 10 deadbeef f", str_adr,
                  str_dat, str_sel);
      end
   endtask

   task automatic test_read;
      int lat, rcyc;
      core_lat = 5; core_rdata = 32'h12345678;
      wb_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0, {1'b0, 1'b1, 32'h12345678}, lat, rcyc);
      total++;
      if (lat !== 8) begin
         bad++;
         $display("FAIL read_latency: %0d cycles, required 8", lat);
      end
      total++;
      if (str_we !== 1'b0 || str_adr !== 8'h04) begin
         bad++;
         $display("FAIL read_strobe: we=%b adr=%h, required 0 04", str_we, str_adr);
      end
   endtask

   task automatic test_core_err;
      int lat, rcyc1, rcyc2;
      core_lat = 0; core_err_cfg = 1'b1;
      wb_xfer(1'b1, 8'h08, 32'h0BADF00D, 4'h3, 1'b0, {1'b1, 1'b0, 32'h0}, lat, rcyc1);
      core_err_cfg = 1'b0;
      wb_xfer(1'b1, 8'h0C, 32'h55AA55AA, 4'hF, 1'b0, {1'b0, 1'b0, 32'h0}, lat, rcyc2);
      total++;
      if (str_cyc !== rcyc1 + 4 || str_adr !== 8'h0C) begin
         bad++;
         $display("FAIL holdoff_next: strobe at=%0d adr=%h, required %0d 0c", str_cyc, str_adr,
                  rcyc1 + 4);
      end
      total++;
      if (wb_dat_o !== 32'h12345678) begin
         bad++;
         $display("FAIL write_keeps_dat: wb_dat_o=%h, required 12345678", wb_dat_o);
      end
   endtask

   task automatic test_timeout;
      int lat, rcyc;
      core_lat = -1; core_rdata = 32'hAAAA5555;
      wb_xfer(1'b0, 8'h40, 32'h0, 4'hF, 1'b0, {1'b1, 1'b1, 32'h12345678}, lat, rcyc);
      total++;
      if (lat !== 19) begin
         bad++;
         $display("FAIL timeout_latency: %0d cycles, required 19", lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat, rcyc, s0;
      logic [7:0] adrs[4] = '{8'h21, 8'h22, 8'h23, 8'h24};
      core_lat = 0; core_rdata = 32'hCAFEF00D;
      s0 = strobe_cnt;
      for (int i = 0; i < 4; i++) begin
         wb_xfer(i == 3 ? 1'b0 : 1'b1, adrs[i], 32'h100 + i, 4'hF, 1'b1,
                 {1'b0, i == 3 ? 1'b1 : 1'b0, 32'hCAFEF00D}, lat, rcyc);
         total++;
         if (lat !== 3 || str_adr !== adrs[i]) begin
            bad++;
            $display("FAIL b2b_xfer%0d: lat=%0d adr=%h, required 3 %h", i, lat, str_adr, adrs[i]);
         end
      end
      repeat (6) @(posedge clk);
      total++;
      if (strobe_cnt - s0 !== 4) begin
         bad++;
         $display("FAIL b2b_strobes: %0d core strobes, required 4", strobe_cnt - s0);
      end
   endtask

   task automatic test_abort_reset;
      int r0, s0, lat, rcyc;
      core_lat = -1;
      r0 = resp_cnt; s0 = strobe_cnt;
      @(posedge clk);
      #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h30;
      repeat (5) @(posedge clk);
      #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (25) @(posedge clk);
      total++;
      if (resp_cnt !== r0 || strobe_cnt - s0 !== 1) begin
         bad++;
         $display("FAIL abort_quiet: resp=%0d strobes=%0d, required 0 1", resp_cnt - r0,
                  strobe_cnt - s0);
      end
      total++;
      if (wb_dat_o !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL abort_dat: wb_dat_o=%h, required cafef00d", wb_dat_o);
      end
      #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 8'h34;
      wb_dat_i = 32'h77; wb_sel_i = 4'h1;
      repeat (6) @(posedge clk);
      #1;
      wb_rst_i = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(negedge clk);
      total++;
      if ({wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_inta_o, core_adr_o, core_dat_o,
           core_sel_o, core_we_o, core_re_o} !== 82'h0) begin
         bad++;
         $display("FAIL reset_midwait: dat=%h adr=%h cdat=%h sel=%h ctl=%b, required all 0",
                  wb_dat_o, core_adr_o, core_dat_o, core_sel_o,
                  {wb_ack_o, wb_err_o, wb_rty_o, wb_inta_o, core_we_o, core_re_o});
      end
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      r0 = resp_cnt;
      repeat (25) @(posedge clk);
      total++;
      if (resp_cnt !== r0) begin
         bad++;
         $display("FAIL reset_no_resp: %0d responses, required 0", resp_cnt - r0);
      end
      core_lat = 0;
      wb_xfer(1'b1, 8'h38, 32'h99, 4'hF, 1'b0, {1'b0, 1'b0, 32'h0}, lat, rcyc);
      total++;
      if (lat !== 3) begin
         bad++;
         $display("FAIL after_reset: latency %0d, required 3", lat);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_core_err();
      test_timeout();
      test_back_to_back();
      test_abort_reset();
      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
